// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared types and helpers for the pipeline hazard resolver.
//   hz_state_t  : resolver FSM states (RUN, LU_STALL, FLUSH, FREEZE)
//   fwd_sel_t   : forwarding mux select encoding
//   hz_ctrl_t   : bundle of pipeline-register control outputs
//   fwd_select  : RAW-flag priority encoder (EX > MEM > WB > register file)
//   event_state : state requested by the non-freeze events (branch > nop)
//   decode_ctrl : Moore decode of a state into the control bundle
// ---------------------------------------------------------------------------
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FLUSH    = 2'd2,
        FREEZE   = 2'd3
    } hz_state_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_WB  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_EX  = 2'd3
    } fwd_sel_t;

    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_stall;
        logic mem_wb_stall;
    } hz_ctrl_t;

    // While a load-use stall is requested the ID instruction is re-issued
    // next cycle, so whatever it forwards now is irrelevant: use the RF.
    function automatic fwd_sel_t fwd_select(
        input logic raw_a,
        input logic raw_b,
        input logic raw_c,
        input logic nop
    );
        fwd_sel_t sel;
        if (nop)        sel = FWD_RF;
        else if (raw_a) sel = FWD_EX;
        else if (raw_b) sel = FWD_MEM;
        else if (raw_c) sel = FWD_WB;
        else            sel = FWD_RF;
        return sel;
    endfunction

    // A taken branch discards the younger instruction, so it beats a
    // load-use stall of that same instruction.
    function automatic hz_state_t event_state(
        input logic branch_taken,
        input logic nop
    );
        hz_state_t st;
        if (branch_taken) st = FLUSH;
        else if (nop)     st = LU_STALL;
        else              st = RUN;
        return st;
    endfunction

    function automatic hz_ctrl_t decode_ctrl(input hz_state_t st);
        hz_ctrl_t c;
        c = '0;
        case (st)
            LU_STALL: begin
                c.pc_stall    = 1'b1;
                c.if_id_stall = 1'b1;
                c.id_ex_flush = 1'b1;
            end
            FLUSH: begin
                c.if_id_flush = 1'b1;
                c.id_ex_flush = 1'b1;
            end
            FREEZE: begin
                c.pc_stall     = 1'b1;
                c.if_id_stall  = 1'b1;
                c.ex_mem_stall = 1'b1;
                c.mem_wb_stall = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// ---------------------------------------------------------------------------
// fwd_mux
// Combinational forwarding mux for one ID-stage source operand.
// Ports:
//   raw_a/raw_b/raw_c : operand matches EX / MEM / WB destination
//   nop               : load-use stall request (suppresses forwarding)
//   rd_rf             : register-file read data
//   wd_ex/wd_mem/wd_wb: in-flight write-back values
//   rd_fwd            : selected operand
// ---------------------------------------------------------------------------
module fwd_mux
    import hazard_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          raw_a,
    input  logic          raw_b,
    input  logic          raw_c,
    input  logic          nop,
    input  logic [DW-1:0] rd_rf,
    input  logic [DW-1:0] wd_ex,
    input  logic [DW-1:0] wd_mem,
    input  logic [DW-1:0] wd_wb,
    output logic [DW-1:0] rd_fwd
);

    fwd_sel_t sel;

    always_comb begin
        sel = fwd_select(raw_a, raw_b, raw_c, nop);
        case (sel)
            FWD_EX:  rd_fwd = wd_ex;
            FWD_MEM: rd_fwd = wd_mem;
            FWD_WB:  rd_fwd = wd_wb;
            default: rd_fwd = rd_rf;
        endcase
    end

endmodule

// File: rtl/hazard_resolver.sv
// ---------------------------------------------------------------------------
// hazard_resolver
// Acts on RAW / load-use hazard flags for a five-stage pipeline: forwards
// ID operands, drives stall/flush enables of the pipeline registers,
// arbitrates bus wait > taken branch > load-use, and keeps saturating
// stall/flush counters plus a sticky consecutive-stall watchdog.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   RAW_{A,B,C}_rR{1,2}         : per-operand EX/MEM/WB match flags
//   nop                         : load-use stall request
//   branch_taken_EX             : taken branch/jump in EX
//   bus_wait                    : memory not ready, freeze everything
//   rD1_ID, rD2_ID              : register-file read data
//   wD_EX, wD_MEM, wD_WB        : in-flight write-back values
//   rD1_fwd, rD2_fwd            : forwarded operands
//   pc_stall ... mem_wb_stall   : pipeline-register controls
//   stall_cnt, flush_cnt        : performance counters (saturating)
//   stall_err                   : sticky watchdog flag
// ---------------------------------------------------------------------------
module hazard_resolver
    import hazard_pkg::*;
#(
    parameter int DW        = 32,
    parameter int CNT_W     = 32,
    parameter int MAX_STALL = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             RAW_A_rR1,
    input  logic             RAW_A_rR2,
    input  logic             RAW_B_rR1,
    input  logic             RAW_B_rR2,
    input  logic             RAW_C_rR1,
    input  logic             RAW_C_rR2,
    input  logic             nop,
    input  logic             branch_taken_EX,
    input  logic             bus_wait,
    input  logic [DW-1:0]    rD1_ID,
    input  logic [DW-1:0]    rD2_ID,
    input  logic [DW-1:0]    wD_EX,
    input  logic [DW-1:0]    wD_MEM,
    input  logic [DW-1:0]    wD_WB,
    output logic [DW-1:0]    rD1_fwd,
    output logic [DW-1:0]    rD2_fwd,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_stall,
    output logic             mem_wb_stall,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             stall_err
);

    localparam int CONS_W = (MAX_STALL < 2) ? 1 : $clog2(MAX_STALL + 1);
    localparam logic [CONS_W-1:0] CONS_MAX = CONS_W'(MAX_STALL);

    // ---------------- forwarding ----------------
    logic [DW-1:0] rd1_mux;
    logic [DW-1:0] rd2_mux;

    fwd_mux #(.DW(DW)) u_fwd_rs1 (
        .raw_a  (RAW_A_rR1),
        .raw_b  (RAW_B_rR1),
        .raw_c  (RAW_C_rR1),
        .nop    (nop),
        .rd_rf  (rD1_ID),
        .wd_ex  (wD_EX),
        .wd_mem (wD_MEM),
        .wd_wb  (wD_WB),
        .rd_fwd (rd1_mux)
    );

    fwd_mux #(.DW(DW)) u_fwd_rs2 (
        .raw_a  (RAW_A_rR2),
        .raw_b  (RAW_B_rR2),
        .raw_c  (RAW_C_rR2),
        .nop    (nop),
        .rd_rf  (rD2_ID),
        .wd_ex  (wD_EX),
        .wd_mem (wD_MEM),
        .wd_wb  (wD_WB),
        .rd_fwd (rd2_mux)
    );

    // ---------------- state ----------------
    hz_state_t         state_q, state_d;
    hz_state_t         pend_q, pend_d;      // event latched on FREEZE entry
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [CONS_W-1:0] consec_q, consec_d;
    logic              stall_err_q, stall_err_d;
    logic              stall_cycle;
    logic              flush_cycle;
    hz_ctrl_t          ctrl;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        if (bus_wait) begin
            state_d = FREEZE;
            if (state_q != FREEZE) begin
                pend_d = event_state(branch_taken_EX, nop);
            end
        end else if (state_q == FREEZE && pend_q != RUN) begin
            // Replay the event that was waiting behind the bus stall.
            state_d = pend_q;
        end else begin
            state_d = event_state(branch_taken_EX, nop);
        end
    end

    always_comb begin
        stall_cycle = (state_d == LU_STALL) || (state_d == FREEZE);
        flush_cycle = (state_d == FLUSH);

        stall_cnt_d = stall_cnt_q;
        if (stall_cycle && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end

        // Every FLUSH cycle stands for exactly one taken branch.
        flush_cnt_d = flush_cnt_q;
        if (flush_cycle && flush_cnt_q != '1) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end

        consec_d = '0;
        if (stall_cycle) begin
            consec_d = (consec_q == CONS_MAX) ? consec_q : consec_q + CONS_W'(1);
        end
        stall_err_d = stall_err_q | (consec_d == CONS_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            pend_q      <= RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            consec_q    <= '0;
            stall_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            consec_q    <= consec_d;
            stall_err_q <= stall_err_d;
        end
    end

    // ---------------- outputs ----------------
    // Controls decode the next state so an event acts in the cycle it is
    // seen; reset forces every output low even while bus_wait is high.
    always_comb begin
        ctrl = rst_n ? decode_ctrl(state_d) : '0;
    end

    assign pc_stall     = ctrl.pc_stall;
    assign if_id_stall  = ctrl.if_id_stall;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_flush  = ctrl.id_ex_flush;
    assign ex_mem_stall = ctrl.ex_mem_stall;
    assign mem_wb_stall = ctrl.mem_wb_stall;

    assign rD1_fwd   = rst_n ? rd1_mux : '0;
    assign rD2_fwd   = rst_n ? rd2_mux : '0;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign stall_err = stall_err_q;

endmodule
